// File: rtl/cpu_pkg.sv
// Shared CPU definitions: HI/LO op encodings, mul/div FSM states and default word width.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_DIVU  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_MULT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; with neg_i = sign bit it yields the magnitude.
module muldiv_signfix #(
    parameter int N = 32
) (
    input  logic [N-1:0] val_i,
    input  logic         neg_i,
    output logic [N-1:0] res_o
);

    assign res_o = neg_i ? ((~val_i) + {{(N-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_engine.sv
// Iterative 32-step multiply/divide unit feeding the HI/LO registers.
// busy stalls the pipeline; done is a one-cycle HI/LO write enable.
module muldiv_engine
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       op_out,
    output state_t           dbg_state
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d, opo_q, opo_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   a_q, a_d, m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix, div_next, mul_next;
    logic [WIDTH:0]     rem_sh, rem_sub, mul_sum;
    logic               div_ovf;

    // Signs only matter for the signed ops (op[0] = 1).
    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];

    muldiv_signfix #(.N(WIDTH))   u_abs_a (.val_i(a), .neg_i(a_neg), .res_o(a_mag));
    muldiv_signfix #(.N(WIDTH))   u_abs_b (.val_i(b), .neg_i(b_neg), .res_o(b_mag));
    muldiv_signfix #(.N(2*WIDTH)) u_prod  (.val_i(acc_q), .neg_i(sa_q ^ sb_q), .res_o(prod_fix));
    muldiv_signfix #(.N(WIDTH))   u_quo   (.val_i(acc_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .res_o(quo_fix));
    muldiv_signfix #(.N(WIDTH))   u_rem   (.val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .res_o(rem_fix));

    // Shifted remainder keeps its carry bit so a divisor above 2^(WIDTH-1) still compares correctly.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_sub  = rem_sh - {1'b0, m_q};
    assign div_next = (rem_sh >= {1'b0, m_q}) ? {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                              : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    assign div_ovf  = (op_q == OP_DIV) && (a_q == MSB_ONLY) && (m_q == WIDTH'(1)) && sb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opo_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opo_q   <= opo_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opo_d   = opo_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        m_d     = m_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    sa_d  = a_neg;
                    sb_d  = b_neg;
                    a_d   = a;
                    cnt_d = '0;
                    if (op[1]) begin
                        m_d   = a_mag;
                        acc_d = {{WIDTH{1'b0}}, b_mag};
                    end else begin
                        m_d   = b_mag;
                        acc_d = {{WIDTH{1'b0}}, a_mag};
                    end
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = op_q[1] ? mul_next : div_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                opo_d   = op_q;
                state_d = S_DONE;
                if (op_q[1]) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (m_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else if (div_ovf) begin
                    hi_d = '0;
                    lo_d = MSB_ONLY;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign op_out    = opo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_engine.sv
// Directed-vector bench for muldiv_engine with hand-computed HI/LO results.
module tb_muldiv_engine;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [1:0]  op_out;
    state_t      dbg_state;

    int tests = 0;
    int fails = 0;
    int lat, bcnt, ndone, fd;
    logic [31:0] rh, rl;

    always #5 clk = ~clk;

    muldiv_engine #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .op_out(op_out),
        .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, scramble operands afterwards, wait (bounded) for done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int l, output int bc);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
        l = 1;
        bc = 0;
        while (!done && l < 100) begin
            if (busy) bc++;
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_opout", 64'(op_out), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;

        // MULTU max * max, with latency and busy length
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        chk("multu_lat", 64'(lat), 64'd34);
        chk("multu_busy", 64'(bcnt), 64'd33);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);
        chk("multu_opout", 64'(op_out), 64'(OP_MULTU));
        @(negedge clk);
        chk("multu_done_1cyc", 64'(done), 64'd0);
        chk("multu_hold_lo", 64'(lo), 64'h0000_0001);

        // MULT -3 * 7
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, lat, bcnt);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFEB);
        chk("mult_opout", 64'(op_out), 64'(OP_MULT));

        // MULT min * min = 2^62
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        chk("mult_min_hi", 64'(hi), 64'h4000_0000);
        chk("mult_min_lo", 64'(lo), 64'h0000_0000);

        // DIV -7 / 2
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_opout", 64'(op_out), 64'(OP_DIV));

        // DIVU 100 / 7, immediately followed by MULTU 6*7 in the cycle after done
        run_op(OP_DIVU, 32'd100, 32'd7, lat, bcnt);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);
        chk("divu_lat", 64'(lat), 64'd34);
        run_op(OP_MULTU, 32'd6, 32'd7, lat, bcnt);
        chk("b2b_lat", 64'(lat), 64'd34);
        chk("b2b_lo", 64'(lo), 64'd42);
        chk("b2b_hi", 64'(hi), 64'd0);

        // DIVU by zero
        run_op(OP_DIVU, 32'h1234_5678, 32'd0, lat, bcnt);
        chk("divu0_hi", 64'(hi), 64'h1234_5678);
        chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);

        // DIV by zero keeps the raw negative dividend
        run_op(OP_DIV, 32'hFFFF_FFF0, 32'd0, lat, bcnt);
        chk("div0_hi", 64'(hi), 64'hFFFF_FFF0);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);

        // DIV overflow case
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        chk("divovf_lo", 64'(lo), 64'h8000_0000);
        chk("divovf_hi", 64'(hi), 64'h0000_0000);

        // start re-pulsed in CALC and in the DONE cycle must be ignored
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        ndone = 0; bcnt = 0; fd = 0; rh = '0; rl = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                op = OP_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
            end
            if (busy) bcnt++;
            if (done) begin
                ndone++;
                if (fd == 0) begin
                    fd = c; rh = hi; rl = lo;
                end
                start = 1'b1;
            end
        end
        start = 1'b0;
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_lat", 64'(fd), 64'd34);
        chk("ign_busy", 64'(bcnt), 64'd33);
        chk("ign_lo", 64'(rl), 64'd14);
        chk("ign_hi", 64'(rh), 64'd2);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_state", 64'(dbg_state), 64'(S_CALC));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_hi", 64'(hi), 64'd0);
        chk("mid_rst_lo", 64'(lo), 64'd0);
        chk("mid_rst_state", 64'(dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MULTU, 32'd3, 32'd5, lat, bcnt);
        chk("post_rst_lat", 64'(lat), 64'd34);
        chk("post_rst_lo", 64'(lo), 64'd15);
        chk("post_rst_hi", 64'(hi), 64'd0);
        chk("post_rst_opout", 64'(op_out), 64'(OP_MULTU));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
